loop_tstate_gate: RTL
=====================

Name: loop_tstate_gate

Overview:
Parametrised multi-channel successor to the single-bit loop-control Tstate gate.
- Each of NCH channels gates its request i0[k] with the global Tstate strobe.
- Each channel carries a loadable iteration counter, so the gate passes at most N Tstate-qualified pulses, then signals done and closes.
- Sits in LOOP/CONTROL between the loop sequencer (loads counts) and the per-channel loop datapath enables (consume o).

Parameters:
NCH, 4, number of independent channels (1..16)
CNT_W, 8, iteration counter width; max loop count 2^CNT_W-1

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  asynchronous, active-high reset
Tstate  input  1  global T-state strobe qualifying all channels
i0  input  NCH  per-channel gate request
load  input  1  load strobe for one channel counter
load_ch  input  $clog2(NCH) (min 1)  channel index for load
load_val  input  CNT_W  iteration count to load
o  output  NCH  gated enable per channel
busy  output  NCH  channel in RUN state
done  output  NCH  one-cycle pulse when a channel's count expires
CELV  input  1  supply tie, no RTL function
CELG  input  1  ground tie, no RTL function
SUB  input  1  substrate tie, no RTL function

Behaviour:
- Clock, reset and power pins: one clock, CLK. Reset RST is asynchronous and active-high. CELV, CELG and SUB are tie pins with no RTL function.
- Reset values: o=0, busy=0, done=0, all counters 0, all channels IDLE. Reset asserted mid-run aborts immediately; no done pulse is generated.
- Per-channel FSM has three states: IDLE, RUN, DONE.
  - IDLE -> RUN: load with load_ch==k and load_val!=0; cnt<=load_val.
  - IDLE -> DONE: load with load_val==0; no o pulse is produced.
  - RUN: a qualify event is i0[k]&Tstate sampled high. It decrements cnt and asserts o[k]. When cnt goes 1->0, next state is DONE.
  - DONE: done[k]=1 for exactly one cycle, then unconditionally IDLE.
- busy[k]=1 iff state==RUN.
- Output latency, default build: o[k] is registered. It is high the cycle after the qualify edge, one pulse per qualify cycle, so back-to-back qualifies give a continuous high. Total o pulses per run equals load_val exactly.
- done timing: done[k] follows the cycle in which the final o[k] asserts.
- Load to a channel in RUN or DONE: restarts that channel (cnt<=load_val; state per IDLE rules). Load wins over a same-cycle decrement, and any pending done pulse is suppressed.
- Only the addressed channel is affected by load. load_ch>=NCH is ignored.
- Tstate or i0 high while IDLE or DONE: no o, no state change.
- Channels are fully independent; simultaneous done on several channels is legal.
- Counter never wraps: decrement occurs only when cnt>0 in RUN.

Optional Feature:
LOOP_TSTATE_COMB_OUT_EN
- Defined: o[k] = i0[k] & Tstate & (state==RUN), combinational. This gives zero latency, identical to the legacy gate while counting.
  - Counter/FSM update is unchanged (registered).
  - done asserts the cycle after the last combinational o.
- Undefined: registered o as above.

Decomposition:
- Package loop_ctrl_pkg holds:
  - loop_state_e enum (IDLE, RUN, DONE)
  - LOOP_CNT_W_DEF = 8 and LOOP_NCH_DEF = 4
  - function ch_idx_w(n) returning max(1, $clog2(n))
- Natural sub-module: loop_tstate_chan, one channel holding FSM + counter + o/done logic. The top generates NCH instances and decodes load_ch.

Test Plan:
- Reset: RST high mid-run on ch0 (cnt=5) -> o, busy, done all 0 immediately; after release, ch0 stays IDLE with no done.
- Basic count: load ch1 val=3, hold i0[1]=1, Tstate=1 -> exactly 3 consecutive o[1] cycles, done[1] pulse one cycle after the last, busy[1] low after.
- Gating: load ch2 val=4, toggle Tstate 1/0 each cycle -> 4 non-contiguous o[2] pulses over 8 cycles; i0[2]=0 cycles produce no pulse and no decrement.
- Zero and illegal load: load ch0 val=0 -> no o[0], done[0] pulses next cycle. With NCH=3, load_ch=3 -> no state change anywhere.
- Reload collision: ch3 at cnt=1 with qualify and load val=2 in the same cycle -> no done; exactly 2 further o[3] pulses then done.
- Independence and macro: all 4 channels loaded 1,2,3,4 with common Tstate -> done pulses on cycles 2,3,4,5. Rerun with LOOP_TSTATE_COMB_OUT_EN -> each o[k] is high in the same cycle as its qualify.

Source files
------------

// File: rtl/loop_ctrl_pkg.sv
// Shared types and defaults for the LOOP/CONTROL Tstate gate.
package loop_ctrl_pkg;

    localparam int unsigned LOOP_CNT_W_DEF = 8;
    localparam int unsigned LOOP_NCH_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } loop_state_e;

    // Channel index width, never below one bit so a single-channel build stays legal.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 32'd1) ? $unsigned($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/loop_tstate_gate_if.sv
// Sequencer-facing bus of the Tstate gate: strobe, requests, counter load, per-channel status.
interface loop_tstate_gate_if
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned NCH   = LOOP_NCH_DEF,
    parameter int unsigned CNT_W = LOOP_CNT_W_DEF
);
    localparam int unsigned IDX_W = ch_idx_w(NCH);

    logic             Tstate;
    logic [NCH-1:0]   i0;
    logic             load;
    logic [IDX_W-1:0] load_ch;
    logic [CNT_W-1:0] load_val;
    logic [NCH-1:0]   o;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;

    modport master (
        output Tstate, i0, load, load_ch, load_val,
        input  o, busy, done
    );

    modport slave (
        input  Tstate, i0, load, load_ch, load_val,
        output o, busy, done
    );

endinterface

// File: rtl/loop_tstate_chan.sv
// One gate channel: IDLE/RUN/DONE FSM, iteration counter, o and done generation.
// LOOP_TSTATE_COMB_OUT_EN selects a zero-latency combinational o; otherwise o is registered.
module loop_tstate_chan
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = LOOP_CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             tstate,
    input  logic             req,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             o,
    output logic             busy,
    output logic             done
);

    loop_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qual_c;

    assign qual_c = tstate & req & (state_q == RUN) & (cnt_q != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load restarts the channel from any state and overrides a same-cycle decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            cnt_d   = load_val;
            state_d = (load_val != '0) ? RUN : DONE;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (qual_c) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);

`ifdef LOOP_TSTATE_COMB_OUT_EN
    assign o    = qual_c;
    assign done = (state_q == DONE);
`else
    logic o_q;
    logic done_q;

    // Both outputs trail the FSM by one cycle, so done lands after the final o pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            o_q    <= qual_c & ~load;
            done_q <= (state_q == DONE) & ~load;
        end
    end

    assign o    = o_q;
    assign done = done_q;
`endif

endmodule

// File: rtl/loop_tstate_gate.sv
// Multi-channel loop-control Tstate gate: NCH counted gate channels plus load_ch decode.
// Output timing per channel is selected by LOOP_TSTATE_COMB_OUT_EN (see loop_tstate_chan).
module loop_tstate_gate
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned NCH   = LOOP_NCH_DEF,
    parameter int unsigned CNT_W = LOOP_CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    loop_tstate_gate_if.slave  bus
);

    localparam int unsigned IDX_W = ch_idx_w(NCH);

    // Supply and substrate ties carry no logic.
    logic unused_ties;
    assign unused_ties = CELV ^ CELG ^ SUB;

    // Out-of-range load_ch matches no channel and is dropped.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        loop_tstate_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .CLK      (CLK),
            .RST      (RST),
            .tstate   (bus.Tstate),
            .req      (bus.i0[k]),
            .load     (bus.load && (bus.load_ch == IDX_W'(k))),
            .load_val (bus.load_val),
            .o        (bus.o[k]),
            .busy     (bus.busy[k]),
            .done     (bus.done[k])
        );
    end

endmodule
